// File: rtl/rot_position.sv
// Rotary position accumulator: saturating/wrapping bounded position with parallel load.
// Define ROT_POS_ACCEL_EN to build the speed-dependent step acceleration FSM.
module rot_position #(
  parameter int WIDTH      = 8,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 99,
  parameter int FAST_GAP   = 100,
  parameter int FAST_COUNT = 3,
  parameter int FAST_STEP  = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             rotated,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pos,
  output logic             changed,
  output logic             at_min,
  output logic             at_max,
  output logic             fast
);

  localparam int XW = WIDTH + 1;
  localparam logic [XW-1:0]    MIN_X       = XW'(MIN_VAL);
  localparam logic [XW-1:0]    MAX_X       = XW'(MAX_VAL);
  localparam logic [XW-1:0]    ONE_X       = XW'(1);
  localparam logic [XW-1:0]    FAST_STEP_X = XW'(FAST_STEP);
  localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_VAL);

  // Elaboration-time guard on the parameter set.
  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL < (1 << WIDTH) &&
        FAST_STEP >= 1 && FAST_STEP <= MAX_VAL - MIN_VAL &&
        FAST_GAP >= 1 && FAST_COUNT >= 1)) begin : g_param_check
    $error("rot_position: illegal parameter combination");
  end

  logic [WIDTH-1:0] pos_q, pos_d;
  logic             changed_q, changed_d;
  logic             at_min_q, at_min_d;
  logic             at_max_q, at_max_d;
  logic             use_fast_step;

  logic [XW-1:0] step_x;
  logic [XW-1:0] pos_x;
  logic [XW-1:0] sum_x;
  logic [XW-1:0] deficit_x;
  logic [XW-1:0] stepped_x;
  logic [XW-1:0] load_x;
  logic [XW-1:0] clamped_x;

  // All range arithmetic is one bit wider so pos+step never overflows.
  always_comb begin
    step_x    = use_fast_step ? FAST_STEP_X : ONE_X;
    pos_x     = {1'b0, pos_q};
    sum_x     = pos_x + step_x;
    deficit_x = MIN_X + step_x - pos_x - ONE_X;
    stepped_x = pos_x;
    if (dir) begin
      if (sum_x <= MAX_X)  stepped_x = sum_x;
      else if (wrap_en)    stepped_x = MIN_X + (sum_x - MAX_X - ONE_X);
      else                 stepped_x = MAX_X;
    end else begin
      if (pos_x >= MIN_X + step_x) stepped_x = pos_x - step_x;
      else if (wrap_en)            stepped_x = MAX_X - deficit_x;
      else                         stepped_x = MIN_X;
    end
  end

  always_comb begin
    load_x    = {1'b0, load_val};
    clamped_x = load_x;
    if (load_x < MIN_X)      clamped_x = MIN_X;
    else if (load_x > MAX_X) clamped_x = MAX_X;
  end

  // Load wins over a same-cycle strobe; the strobe is simply dropped.
  always_comb begin
    pos_d = pos_q;
    if (load)         pos_d = clamped_x[WIDTH-1:0];
    else if (rotated) pos_d = stepped_x[WIDTH-1:0];
    changed_d = (pos_d != pos_q);
    at_min_d  = (pos_d == MIN_W);
    at_max_d  = (pos_d == MAX_W);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pos_q     <= MIN_W;
      changed_q <= 1'b0;
      at_min_q  <= 1'b1;
      at_max_q  <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      changed_q <= changed_d;
      at_min_q  <= at_min_d;
      at_max_q  <= at_max_d;
    end
  end

  assign pos     = pos_q;
  assign changed = changed_q;
  assign at_min  = at_min_q;
  assign at_max  = at_max_q;

`ifdef ROT_POS_ACCEL_EN
  localparam int TW = (FAST_GAP   < 1) ? 1 : $clog2(FAST_GAP + 1);
  localparam int SW = (FAST_COUNT < 1) ? 1 : $clog2(FAST_COUNT + 1);
  localparam logic [TW-1:0] GAP_T   = TW'(FAST_GAP);
  localparam logic [SW-1:0] COUNT_S = SW'(FAST_COUNT);

  typedef enum logic {ST_SLOW, ST_FAST} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d, streak_inc;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_dir_q, last_dir_d;
  logic          quick;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_SLOW;
      streak_q   <= '0;
      timer_q    <= GAP_T;
      last_dir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      timer_q    <= timer_d;
      last_dir_q <= last_dir_d;
    end
  end

  // A detent is "quick" when it continues the same direction before the gap timer saturates.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    last_dir_d    = last_dir_q;
    use_fast_step = 1'b0;
    quick         = (dir == last_dir_q) && (timer_q < GAP_T);
    streak_inc    = (streak_q < COUNT_S) ? streak_q + SW'(1) : COUNT_S;
    timer_d       = (timer_q < GAP_T) ? timer_q + TW'(1) : GAP_T;
    if (load) begin
      state_d  = ST_SLOW;
      streak_d = '0;
      timer_d  = GAP_T;
    end else if (rotated) begin
      timer_d    = '0;
      last_dir_d = dir;
      unique case (state_q)
        ST_SLOW: begin
          streak_d = quick ? streak_inc : SW'(1);
          if (quick ? (streak_inc >= COUNT_S) : (COUNT_S <= SW'(1))) state_d = ST_FAST;
        end
        ST_FAST: begin
          if (quick) begin
            use_fast_step = 1'b1;
          end else begin
            state_d  = ST_SLOW;
            streak_d = SW'(1);
          end
        end
      endcase
    end else if (state_q == ST_FAST && timer_d == GAP_T) begin
      state_d  = ST_SLOW;
      streak_d = '0;
    end
  end

  always_comb begin
    fast = (state_q == ST_FAST);
  end
`else
  always_comb begin
    use_fast_step = 1'b0;
    fast          = 1'b0;
  end
`endif

endmodule
